// File: rtl/code_lock_ctrl.sv
// -----------------------------------------------------------------------------
// code_lock_ctrl
//
// Keypad code checker in front of the stepper drive. Decimal digits from the
// keypad decoder are shifted into a buffer. On ENTER the buffer is compared
// against SECRET.
//  - A correct code holds match high for UNLOCK_CYCLES cycles so the stepper
//    can turn the bolt.
//  - MAX_TRIES consecutive wrong codes raise alarm for LOCKOUT_CYCLES cycles.
//
// Ports
//  clk        in   1   system clock, all logic on posedge
//  reset      in   1   synchronous, active-high; wins over everything
//  key_valid  in   1   one-cycle strobe qualifying key_code
//  key_code   in   4   0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC-F ignored
//  match      out  1   registered, high for the unlock window
//  alarm      out  1   registered, high for the whole lockout
//  fail_cnt   out  3   consecutive failed attempts
//  digit_cnt  out  4   digits buffered; CODE_LEN+1 means "too long"
//  fsm_state  out  3   debug view of the FSM:
//                      0 IDLE, 1 CHECK, 2 UNLOCK, 3 FAIL, 4 LOCKOUT
//
// Key interface: key_valid/key_code is a strobe with no back-pressure. A key
// is consumed only if it is sampled while the FSM is in IDLE. Keys seen in any
// other state, including the cycle on which a timed state exits, are dropped.
// -----------------------------------------------------------------------------
module code_lock_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] SECRET         = 16'h1234,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    UNLOCK_CYCLES  = 2_000_000,
  parameter int                    LOCKOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       match,
  output logic       alarm,
  output logic [2:0] fail_cnt,
  output logic [3:0] digit_cnt,
  output logic [2:0] fsm_state
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
  localparam logic [3:0]    DIGIT_SAT    = 4'(CODE_LEN + 1);
  localparam logic [3:0]    DIGIT_FULL   = 4'(CODE_LEN);
  localparam logic [2:0]    TRIES_LIMIT  = 3'(MAX_TRIES);

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    UNLOCK  = 3'd2,
    FAIL    = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t                state;
  logic [4*CODE_LEN-1:0] code_buf;
  logic [TW-1:0]         timer;

  // Shift through a widened vector so CODE_LEN=1 needs no special case.
  logic [4*CODE_LEN+3:0] shifted;
  logic                  code_ok;
  logic [2:0]            fail_next;

  assign shifted   = {code_buf, key_code};
  assign code_ok   = (digit_cnt == DIGIT_FULL) && (code_buf == SECRET);
  assign fail_next = fail_cnt + 3'd1;
  assign fsm_state = state;

  // Timed states are entered with the full cycle count loaded. The registered
  // output is raised on each following edge while the count is non-zero. So
  // match/alarm are high for exactly the loaded number of cycles. The state
  // is left on the edge that sees the count at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      match     <= 1'b0;
      alarm     <= 1'b0;
      fail_cnt  <= 3'd0;
      digit_cnt <= 4'd0;
      code_buf  <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              code_buf <= shifted[4*CODE_LEN-1:0];
              if (digit_cnt != DIGIT_SAT) begin
                digit_cnt <= digit_cnt + 4'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              code_buf  <= '0;
              digit_cnt <= 4'd0;
            end else if (key_code == KEY_ENTER && digit_cnt != 4'd0) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          code_buf  <= '0;
          digit_cnt <= 4'd0;
          if (code_ok) begin
            state    <= UNLOCK;
            timer    <= UNLOCK_LOAD;
            fail_cnt <= 3'd0;
          end else begin
            state <= FAIL;
          end
        end

        UNLOCK: begin
          if (timer == '0) begin
            state <= IDLE;
            match <= 1'b0;
          end else begin
            timer <= timer - TIMER_ONE;
            match <= 1'b1;
          end
        end

        FAIL: begin
          fail_cnt <= fail_next;
          if (fail_next == TRIES_LIMIT) begin
            state <= LOCKOUT;
            timer <= LOCKOUT_LOAD;
          end else begin
            state <= IDLE;
          end
        end

        LOCKOUT: begin
          if (timer == '0) begin
            state    <= IDLE;
            alarm    <= 1'b0;
            fail_cnt <= 3'd0;
          end else begin
            timer <= timer - TIMER_ONE;
            alarm <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_code_lock_ctrl
//
// Bench for code_lock_ctrl with short timers: unlock 8 cycles, lockout 16.
//
// The reference model works on key events and edge timestamps:
//  - An accepted ENTER at edge e opens a match window or an alarm window,
//    expressed as edge ranges.
//  - It schedules fail_cnt and digit-buffer updates at later edges.
//  - Keys count only from the edge at which the lock is idle again.
// -----------------------------------------------------------------------------
module tb_code_lock_ctrl;

  localparam int CODE_LEN = 4;
  localparam int MAX_TRIES = 3;
  localparam int UNLOCK_CYCLES = 8;
  localparam int LOCKOUT_CYCLES = 16;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       match;
  logic       alarm;
  logic [2:0] fail_cnt;
  logic [3:0] digit_cnt;
  logic [2:0] fsm_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  code_lock_ctrl #(
    .CODE_LEN(CODE_LEN),
    .SECRET(16'h1234),
    .MAX_TRIES(MAX_TRIES),
    .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .match(match),
    .alarm(alarm),
    .fail_cnt(fail_cnt),
    .digit_cnt(digit_cnt),
    .fsm_state(fsm_state)
  );

  // ---------------- reference model ----------------
  int         secret_digits[4] = '{1, 2, 3, 4};
  int         dq[$];
  int         e = 0;
  int         idle_from = 0;
  int         un_lo = -1;
  int         un_hi = -2;
  int         al_lo = -1;
  int         al_hi = -2;
  int         dclr_e = -1;
  int         fev_e[$];
  logic [2:0] fev_v[$];
  logic       m_match = 1'b0;
  logic       m_alarm = 1'b0;
  logic [2:0] m_fail = 3'd0;
  logic [3:0] m_dig = 4'd0;

  task automatic model_step(input logic kv, input logic [3:0] kc, input logic rst);
    bit ok;
    int nf;
    e++;
    if (rst) begin
      dq.delete();
      fev_e.delete();
      fev_v.delete();
      m_fail = 3'd0;
      un_lo = -1; un_hi = -2;
      al_lo = -1; al_hi = -2;
      dclr_e = -1;
      idle_from = e + 1;
    end else begin
      if (dclr_e == e) dq.delete();
      while (fev_e.size() > 0 && fev_e[0] == e) begin
        m_fail = fev_v[0];
        void'(fev_e.pop_front());
        void'(fev_v.pop_front());
      end
      if (kv && e >= idle_from) begin
        if (kc <= 4'd9) begin
          dq.push_back(int'(kc));
        end else if (kc == KEY_CLEAR) begin
          dq.delete();
        end else if (kc == KEY_ENTER && dq.size() > 0) begin
          ok = (dq.size() == CODE_LEN);
          if (ok) begin
            for (int i = 0; i < CODE_LEN; i++) if (dq[i] != secret_digits[i]) ok = 0;
          end
          dclr_e = e + 1;
          if (ok) begin
            un_lo = e + 2;
            un_hi = e + 1 + UNLOCK_CYCLES;
            fev_e.push_back(e + 1); fev_v.push_back(3'd0);
            idle_from = e + UNLOCK_CYCLES + 3;
          end else begin
            nf = int'(m_fail) + 1;
            fev_e.push_back(e + 2); fev_v.push_back(3'(nf));
            if (nf == MAX_TRIES) begin
              al_lo = e + 3;
              al_hi = e + 2 + LOCKOUT_CYCLES;
              fev_e.push_back(e + LOCKOUT_CYCLES + 3); fev_v.push_back(3'd0);
              idle_from = e + LOCKOUT_CYCLES + 4;
            end else begin
              idle_from = e + 3;
            end
          end
        end
      end
    end
    m_match = (e >= un_lo && e <= un_hi);
    m_alarm = (e >= al_lo && e <= al_hi);
    m_dig = (dq.size() > CODE_LEN) ? 4'(CODE_LEN + 1) : 4'(dq.size());
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic kv, input logic [3:0] kc, input logic rst);
    key_valid = kv;
    key_code = kc;
    reset = rst;
    @(posedge clk);
    model_step(kv, kc, rst);
    @(negedge clk);
    key_valid = 1'b0;
    key_code = 4'd0;
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] kc);
    tick(1'b1, kc, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 4'd0, 1'b1);
    tick(1'b0, 4'd0, 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tick(1'b1, 4'd5, 1'b1);
    checks++;
    if (match !== 1'b0 || alarm !== 1'b0 || fail_cnt !== 3'd0 || digit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs match=%b alarm=%b fail_cnt=%0d digit_cnt=%0d expected all 0",
               match, alarm, fail_cnt, digit_cnt);
    end
    checks++;
    if (fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state fsm_state=%0d expected 0 (IDLE)", fsm_state);
    end
    press(4'd7);
    checks++;
    if (digit_cnt !== 4'd1) begin
      errors++;
      $display("FAIL first_key_after_reset digit_cnt=%0d expected 1", digit_cnt);
    end
  endtask

  task automatic test_correct_code();
    int rise = 0;
    int high = 0;
    do_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++;
    if (digit_cnt !== 4'd4) begin
      errors++;
      $display("FAIL correct_digits digit_cnt=%0d expected 4", digit_cnt);
    end
    press(KEY_ENTER);
    for (int k = 1; k <= 14; k++) begin
      tick(1'b0, 4'd0, 1'b0);
      checks++;
      if (match !== m_match || alarm !== m_alarm || fail_cnt !== m_fail || digit_cnt !== m_dig) begin
        errors++;
        $display("FAIL correct_code k=%0d match=%b/%b alarm=%b/%b fail_cnt=%0d/%0d digit_cnt=%0d/%0d (got/exp)",
                 k, match, m_match, alarm, m_alarm, fail_cnt, m_fail, digit_cnt, m_dig);
      end
      if (match === 1'b1) begin
        if (rise == 0) rise = k;
        high++;
      end
    end
    checks++;
    if (rise !== 2) begin
      errors++;
      $display("FAIL match_latency got %0d edges expected 2", rise);
    end
    checks++;
    if (high !== UNLOCK_CYCLES) begin
      errors++;
      $display("FAIL match_width got %0d cycles expected %0d", high, UNLOCK_CYCLES);
    end
    checks++;
    if (fail_cnt !== 3'd0 || match !== 1'b0) begin
      errors++;
      $display("FAIL after_unlock fail_cnt=%0d match=%b expected 0 0", fail_cnt, match);
    end
  endtask

  task automatic test_wrong_then_right();
    bit seen = 0;
    do_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(KEY_ENTER);
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0, 4'd0, 1'b0);
      checks++;
      if (match !== m_match || alarm !== m_alarm || fail_cnt !== m_fail || digit_cnt !== m_dig) begin
        errors++;
        $display("FAIL wrong_code k=%0d match=%b/%b alarm=%b/%b fail_cnt=%0d/%0d digit_cnt=%0d/%0d (got/exp)",
                 k, match, m_match, alarm, m_alarm, fail_cnt, m_fail, digit_cnt, m_dig);
      end
    end
    checks++;
    if (fail_cnt !== 3'd1 || match !== 1'b0) begin
      errors++;
      $display("FAIL wrong_code_count fail_cnt=%0d match=%b expected 1 0", fail_cnt, match);
    end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER);
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 4'd0, 1'b0);
      checks++;
      if (match !== m_match || alarm !== m_alarm || fail_cnt !== m_fail || digit_cnt !== m_dig) begin
        errors++;
        $display("FAIL retry_code k=%0d match=%b/%b alarm=%b/%b fail_cnt=%0d/%0d digit_cnt=%0d/%0d (got/exp)",
                 k, match, m_match, alarm, m_alarm, fail_cnt, m_fail, digit_cnt, m_dig);
      end
      if (match === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || fail_cnt !== 3'd0) begin
      errors++;
      $display("FAIL retry_unlock seen_match=%0d fail_cnt=%0d expected 1 0", seen, fail_cnt);
    end
  endtask

  task automatic test_lockout();
    int         al = 0;
    bit         saw_match = 0;
    logic [3:0] during[5] = '{4'd1, 4'd2, 4'd3, 4'd4, KEY_ENTER};
    do_reset();
    for (int t = 0; t < MAX_TRIES; t++) begin
      press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(KEY_ENTER);
      if (t < MAX_TRIES - 1) begin
        repeat (3) tick(1'b0, 4'd0, 1'b0);
        checks++;
        if (fail_cnt !== 3'(t + 1) || alarm !== 1'b0) begin
          errors++;
          $display("FAIL lockout_try%0d fail_cnt=%0d alarm=%b expected %0d 0", t, fail_cnt, alarm, t + 1);
        end
      end
    end
    for (int k = 1; k <= 26; k++) begin
      if (k >= 5 && k <= 9) press(during[k-5]);
      else tick(1'b0, 4'd0, 1'b0);
      checks++;
      if (match !== m_match || alarm !== m_alarm || fail_cnt !== m_fail || digit_cnt !== m_dig) begin
        errors++;
        $display("FAIL lockout k=%0d match=%b/%b alarm=%b/%b fail_cnt=%0d/%0d digit_cnt=%0d/%0d (got/exp)",
                 k, match, m_match, alarm, m_alarm, fail_cnt, m_fail, digit_cnt, m_dig);
      end
      if (alarm === 1'b1) al++;
      if (match === 1'b1) saw_match = 1;
    end
    checks++;
    if (al !== LOCKOUT_CYCLES || saw_match) begin
      errors++;
      $display("FAIL alarm_width got %0d cycles match_seen=%0d expected %0d 0", al, saw_match, LOCKOUT_CYCLES);
    end
    checks++;
    if (fail_cnt !== 3'd0 || alarm !== 1'b0 || digit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL after_lockout fail_cnt=%0d alarm=%b digit_cnt=%0d expected 0 0 0", fail_cnt, alarm, digit_cnt);
    end
  endtask

  task automatic test_length();
    do_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    checks++;
    if (digit_cnt !== 4'd5) begin
      errors++;
      $display("FAIL too_long_count digit_cnt=%0d expected 5", digit_cnt);
    end
    press(4'd6);
    checks++;
    if (digit_cnt !== 4'd5) begin
      errors++;
      $display("FAIL digit_saturate digit_cnt=%0d expected 5", digit_cnt);
    end
    press(KEY_ENTER);
    repeat (4) tick(1'b0, 4'd0, 1'b0);
    checks++;
    if (fail_cnt !== 3'd1 || match !== 1'b0) begin
      errors++;
      $display("FAIL too_long_fail fail_cnt=%0d match=%b expected 1 0", fail_cnt, match);
    end
    press(4'd1); press(4'd2); press(4'd3); press(KEY_ENTER);
    repeat (4) tick(1'b0, 4'd0, 1'b0);
    checks++;
    if (fail_cnt !== 3'd2 || match !== 1'b0) begin
      errors++;
      $display("FAIL too_short_fail fail_cnt=%0d match=%b expected 2 0", fail_cnt, match);
    end
    press(KEY_ENTER);
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0, 4'd0, 1'b0);
      checks++;
      if (match !== m_match || alarm !== m_alarm || fail_cnt !== m_fail || digit_cnt !== m_dig) begin
        errors++;
        $display("FAIL bare_enter k=%0d match=%b/%b alarm=%b/%b fail_cnt=%0d/%0d digit_cnt=%0d/%0d (got/exp)",
                 k, match, m_match, alarm, m_alarm, fail_cnt, m_fail, digit_cnt, m_dig);
      end
    end
    checks++;
    if (fail_cnt !== 3'd2 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL bare_enter_ignored fail_cnt=%0d alarm=%b expected 2 0", fail_cnt, alarm);
    end
  endtask

  task automatic test_clear_ignored();
    bit seen = 0;
    do_reset();
    press(4'd7); press(KEY_CLEAR);
    checks++;
    if (digit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clear digit_cnt=%0d expected 0", digit_cnt);
    end
    press(4'd1); press(4'hD); press(4'd2); press(4'hE); press(4'd3); press(4'hF); press(4'hC); press(4'd4);
    checks++;
    if (digit_cnt !== 4'd4) begin
      errors++;
      $display("FAIL ignored_keys digit_cnt=%0d expected 4", digit_cnt);
    end
    press(KEY_ENTER);
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 4'd0, 1'b0);
      checks++;
      if (match !== m_match || alarm !== m_alarm || fail_cnt !== m_fail || digit_cnt !== m_dig) begin
        errors++;
        $display("FAIL clear_unlock k=%0d match=%b/%b alarm=%b/%b fail_cnt=%0d/%0d digit_cnt=%0d/%0d (got/exp)",
                 k, match, m_match, alarm, m_alarm, fail_cnt, m_fail, digit_cnt, m_dig);
      end
      if (match === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL clear_then_code match never rose, expected unlock");
    end
  endtask

  task automatic test_reset_mid_unlock();
    do_reset();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(KEY_ENTER);
    repeat (4) tick(1'b0, 4'd0, 1'b0);
    checks++;
    if (match !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_unlock match=%b expected 1", match);
    end
    tick(1'b0, 4'd0, 1'b1);
    checks++;
    if (match !== 1'b0 || alarm !== 1'b0 || fail_cnt !== 3'd0 || digit_cnt !== 4'd0 || fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_unlock match=%b alarm=%b fail_cnt=%0d digit_cnt=%0d state=%0d expected all 0",
               match, alarm, fail_cnt, digit_cnt, fsm_state);
    end
    press(4'd3);
    checks++;
    if (digit_cnt !== 4'd1) begin
      errors++;
      $display("FAIL key_after_abort digit_cnt=%0d expected 1", digit_cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] seq[$];
    logic       rst;
    for (int it = 0; it < 80; it++) begin
      seq.delete();
      case ($urandom_range(0, 5))
        0: begin
          seq.push_back({1'b1, 4'd1}); seq.push_back({1'b1, 4'd2});
          seq.push_back({1'b1, 4'd3}); seq.push_back({1'b1, 4'd4});
        end
        1: repeat ($urandom_range(1, 6)) seq.push_back({1'b1, 4'($urandom_range(0, 9))});
        2: begin
          seq.push_back({1'b1, 4'd1}); seq.push_back({1'b1, 4'd2}); seq.push_back({1'b1, KEY_CLEAR});
          seq.push_back({1'b1, 4'd1}); seq.push_back({1'b1, 4'd2});
          seq.push_back({1'b1, 4'd3}); seq.push_back({1'b1, 4'd4});
        end
        3: repeat (3) seq.push_back({1'b1, 4'($urandom_range(12, 15))});
        4: begin
          seq.push_back({1'b1, 4'd1}); seq.push_back({1'b1, 4'd2});
          seq.push_back({1'b1, 4'd3}); seq.push_back({1'b1, 4'd4});
          seq.push_back({1'b1, 4'($urandom_range(0, 9))});
        end
        default: repeat (4) seq.push_back({1'b1, 4'd9});
      endcase
      if ($urandom_range(0, 3) != 0) seq.push_back({1'b1, KEY_ENTER});
      repeat ($urandom_range(0, 24)) seq.push_back(5'd0);
      foreach (seq[i]) begin
        rst = ($urandom_range(0, 199) == 0);
        tick(seq[i][4], seq[i][3:0], rst);
        checks++;
        if (match !== m_match || alarm !== m_alarm || fail_cnt !== m_fail || digit_cnt !== m_dig) begin
          errors++;
          $display("FAIL random it=%0d i=%0d match=%b/%b alarm=%b/%b fail_cnt=%0d/%0d digit_cnt=%0d/%0d (got/exp)",
                   it, i, match, m_match, alarm, m_alarm, fail_cnt, m_fail, digit_cnt, m_dig);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_correct_code();
    test_wrong_then_right();
    test_lockout();
    test_length();
    test_clear_ignored();
    test_reset_mid_unlock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
